rtl_sacc: RTL and testbench
===========================

# rtl_sacc

Downstream accumulation stage for the packed-SIMD adder. It consumes the adder's 32-bit result stream, treated as four signed 8-bit lanes, together with its valid strobe. It sums a programmed number of results per lane into widened accumulators and presents the packed totals under the HLS `ap_ctrl_hs` block protocol. It sits directly behind the SIMD adder inside the same extern RTL kernel.

## Interface
- `LANES`, 4, number of packed lanes in `x`.
- `LANE_W`, 8, input lane width in bits, signed.
- `ACC_W`, 16, accumulator width per lane in bits, signed; must satisfy `ACC_W >= LANE_W`.
- `ap_clk`  in  1  single clock; all state updates on its rising edge.
- `ap_rst_n`  in  1  asynchronous, active-low reset.
- `ap_ce`  in  1  clock enable; when low, all state holds.
- `ap_start`  in  1  starts a transaction (sampled in IDLE).
- `ap_continue`  in  1  acknowledges a result (sampled in DONE).
- `len`  in  16  number of `x` words to accumulate; latched at start.
- `x`  in  LANES*LANE_W  packed lanes; lane i is `x[i*LANE_W +: LANE_W]`.
- `x_ap_vld`  in  1  `x` is valid this cycle.
- `ap_idle`  out  1  high when in IDLE.
- `ap_ready`  out  1  one-cycle pulse when the start is accepted.
- `ap_done`  out  1  high throughout DONE.
- `acc`  out  LANES*ACC_W  packed lane sums; lane i is `acc[i*ACC_W +: ACC_W]`.
- `acc_ap_vld`  out  1  equals `ap_done`.

## Operation
- The FSM has three states: IDLE, ACCUM and DONE. All transitions and register updates require `ap_ce=1`.
- IDLE with `ap_start=1`:
  - Latch `len`, clear all accumulators, set `cnt=0`, pulse `ap_ready`.
  - If `len==0`, go to DONE; otherwise go to ACCUM.
- IDLE with `ap_start=0`: hold state.
- ACCUM with `x_ap_vld=1`:
  - Each lane: `acc_i <= acc_i + sext(x_i)`.
  - Increment `cnt`.
  - If `cnt == len_q-1`, go to DONE.
- ACCUM with `x_ap_vld=0`: hold state.
- `x_ap_vld` is ignored in IDLE and DONE. No sample is accepted in the start cycle.
- DONE:
  - `acc` is held stable.
  - `ap_continue=1` returns the block to IDLE.
  - If `ap_start` is also high in that cycle, the start is not accepted until the next cycle in IDLE.
- Lane arithmetic:
  - Each lane is independent; there is no carry between lanes.
  - Without saturation, each sum wraps modulo 2^ACC_W (see Configuration).
- Reset:
  - `ap_rst_n` low at any time, including mid-ACCUM, forces IDLE, `acc=0`, `cnt=0`, `len_q=0` immediately.
  - Accumulated data is discarded.
- Reset values of outputs: `ap_idle=1`, `ap_ready=0`, `ap_done=0`, `acc_ap_vld=0`, `acc=0`.

## Timing
- `ap_ready` is high in the cycle where IDLE samples `ap_start=1` and `ap_ce=1`.
- `ap_idle` falls on the following clock edge.
- `ap_done` and `acc_ap_vld` are registered. They rise on the edge that accepts the final sample, so they are visible the cycle after the last valid `x`.
- Minimum latency, from the start-accept edge to `ap_done`, is `len` cycles, reached when `x_ap_vld` is held high. With `len==0` it is 1 cycle.
- Throughput is one sample per cycle in ACCUM, with no bubbles.
- `ap_ce=0` stalls everything for that cycle:
  - A sample presented with `ap_ce=0` is not consumed.
  - Outputs hold their values.
  - No `ap_ready` pulse is generated while `ap_ce=0`.

## Configuration
- `RTL_SACC_SAT_EN` defined: each lane add saturates to the signed range of ACC_W, i.e. [-2^(ACC_W-1), 2^(ACC_W-1)-1]. A lane that reaches a bound stays clamped until a later add brings it back in range.
- `RTL_SACC_SAT_EN` undefined: each lane add wraps modulo 2^ACC_W.
- The macro has no effect on the interface, timing or FSM.

## Test plan
- Reset, then hold idle -> `ap_idle=1`, `ap_done=0`, `acc=0`. Pulse `ap_rst_n` low mid-ACCUM -> IDLE, `acc=0`, next transaction unaffected.
- `len=4`, `x=0x01FF7F80` valid on 4 consecutive cycles -> `acc=0x0004_FFFC_01FC_FE00`; `ap_done` rises 4 cycles after the start-accept edge and is held until `ap_continue`.
- `len=3` with `x_ap_vld` pattern 1,0,0,1,1 and `x=0x00000001` -> lane0=3, `ap_done` after the 5th cycle; an extra valid `x` in DONE is ignored.
- `len=0` -> `ap_ready` pulse, `ap_done` next cycle, `acc=0`.
- `len=300`, `x=0x0000007F` every cycle:
  - with `RTL_SACC_SAT_EN` -> lane0 = 0x7FFF;
  - without it -> lane0 = 0x94D4.
  - Other lanes are 0 in both builds.
- `ap_ce=0` for 2 cycles mid-stream with `x_ap_vld=1` -> those samples are not counted and the result equals an un-stalled run with the same accepted samples.

Source files
------------

// File: rtl/rtl_sacc_if.sv
// rtl_sacc_if: bundles the ap_ctrl_hs block handshake, the packed input
// sample stream and the packed result of the SIMD accumulation stage.
// The accumulator (rtl_sacc) connects through the slave modport. The
// upstream driver connects through the master modport.
interface rtl_sacc_if #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  parameter int ACC_W  = 16
);
  // Block control
  logic                     ap_start;
  logic                     ap_continue;
  logic                     ap_idle;
  logic                     ap_ready;
  logic                     ap_done;
  // Transaction length, captured when the start is accepted
  logic [15:0]              len;
  // Sample stream
  logic [LANES*LANE_W-1:0]  x;
  logic                     x_ap_vld;
  // Result
  logic [LANES*ACC_W-1:0]   acc;
  logic                     acc_ap_vld;

  modport master (
    output ap_start, ap_continue, len, x, x_ap_vld,
    input  ap_idle, ap_ready, ap_done, acc, acc_ap_vld
  );

  modport slave (
    input  ap_start, ap_continue, len, x, x_ap_vld,
    output ap_idle, ap_ready, ap_done, acc, acc_ap_vld
  );
endinterface

// File: rtl/rtl_sacc.sv
// rtl_sacc: accumulation stage placed behind the packed-SIMD adder.
// It sums `len` packed words per lane into widened signed accumulators and
// returns the packed totals under the ap_ctrl_hs block protocol.
// Optional feature: define RTL_SACC_SAT_EN for saturating lane adds.
// When it is undefined, the lane adds wrap modulo 2^ACC_W.
//
// Handshake semantics:
//   - A start is accepted in any cycle where the block is in IDLE, ap_start=1
//     and ap_ce=1. ap_ready is high in that same cycle.
//   - A sample is consumed in any cycle where the block is in ACCUM,
//     x_ap_vld=1 and ap_ce=1. The block does not backpressure samples, so
//     there is no ready signal on the stream.
//   - ap_done and acc_ap_vld stay high in DONE. The result is released in a
//     cycle with ap_continue=1 and ap_ce=1.
//   - With ap_ce=0 nothing is accepted, consumed or released.
module rtl_sacc #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        ap_ce,
  rtl_sacc_if.slave   bus,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic   [15:0]                 r_len;
  logic   [15:0]                 r_cnt;
  logic   [LANES-1:0][ACC_W-1:0] r_acc;
  logic   [LANES-1:0][ACC_W-1:0] w_acc_nxt;
  logic                          w_start_acc;
  logic                          w_take;
  logic                          w_last;

  // The last sample is the one that makes the count reach the latched length
  assign w_last = (r_cnt == (r_len - 16'd1));

  // Next-state and per-cycle control decode; ap_ce gates every transition
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_take      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ap_ce && bus.ap_start) begin
          w_start_acc = 1'b1;
          w_state_nxt = (bus.len == 16'd0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (ap_ce && bus.x_ap_vld) begin
          w_take = 1'b1;
          if (w_last) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (ap_ce && bus.ap_continue) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Per-lane adders. Lanes are independent, so no carry crosses a lane.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [LANE_W-1:0] w_x;
    logic signed [ACC_W-1:0]  w_x_ext;
    logic signed [ACC_W-1:0]  w_acc_s;

    assign w_x     = bus.x[g*LANE_W +: LANE_W];
    assign w_x_ext = ACC_W'(w_x);
    assign w_acc_s = r_acc[g];

`ifdef RTL_SACC_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    logic [ACC_W:0] w_sum;

    // One guard bit detects overflow: the top two bits differ only when
    // the true sum is outside the ACC_W signed range.
    assign w_sum = {w_acc_s[ACC_W-1], w_acc_s} + {w_x_ext[ACC_W-1], w_x_ext};

    // Clamp to the signed bound on the side the overflow went
    always_comb begin
      w_acc_nxt[g] = w_sum[ACC_W-1:0];
      if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
        w_acc_nxt[g] = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end
    end
`else
    // Wrapping add: plain ACC_W-bit two's complement sum
    always_comb begin
      w_acc_nxt[g] = w_acc_s + w_x_ext;
    end
`endif
  end

  // Datapath: latch the length and clear on start, accumulate on each consumed sample
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_len <= 16'd0;
      r_cnt <= 16'd0;
      r_acc <= '0;
    end else if (w_start_acc) begin
      r_len <= bus.len;
      r_cnt <= 16'd0;
      r_acc <= '0;
    end else if (w_take) begin
      r_cnt <= r_cnt + 16'd1;
      r_acc <= w_acc_nxt;
    end
  end

  // ap_ready is combinational, so it pulses in the cycle that accepts the start
  assign bus.ap_idle    = (r_state == S_IDLE);
  assign bus.ap_ready   = w_start_acc;
  assign bus.ap_done    = (r_state == S_DONE);
  assign bus.acc_ap_vld = (r_state == S_DONE);
  assign bus.acc        = r_acc;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_rtl_sacc.sv
// tb_rtl_sacc: randomized and directed stimulus for rtl_sacc.
// A reference model sums the accepted samples per lane with integer
// arithmetic. A separate monitor compares the results when acc_ap_vld is high.
module tb_rtl_sacc;

  logic       ap_clk = 1'b0;
  logic       ap_rst_n = 1'b0;
  logic       ap_ce = 1'b0;
  logic [1:0] dbg_state;

  rtl_sacc_if #(.LANES(4), .LANE_W(8), .ACC_W(16)) bus ();

  rtl_sacc u_dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .ap_ce     (ap_ce),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 ap_clk = ~ap_clk;

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_q[$];
  logic [63:0] cur_exp = '0;
  bit          prev_vld = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops an expected result when acc_ap_vld rises. It checks acc on
  // every cycle that acc_ap_vld stays high, so acc must not change in DONE.
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      prev_vld = 1'b0;
    end else begin
      if (bus.acc_ap_vld && !prev_vld) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mon_unexpected actual=%h required=none", bus.acc);
          cur_exp = 'x;
        end else begin
          cur_exp = exp_q.pop_front();
        end
      end
      if (bus.acc_ap_vld) chk("mon_acc", bus.acc, cur_exp);
      prev_vld = bus.acc_ap_vld;
    end
  end

  // ---------------- reference model ----------------
  int model_sum[4];

  task automatic model_clear();
    for (int i = 0; i < 4; i++) model_sum[i] = 0;
  endtask

  task automatic model_add(input logic [31:0] xw);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = xw[i*8 +: 8];
      model_sum[i] = model_sum[i] + int'($signed(b));
`ifdef RTL_SACC_SAT_EN
      if (model_sum[i] > 32767)  model_sum[i] = 32767;
      if (model_sum[i] < -32768) model_sum[i] = -32768;
`endif
    end
  endtask

  // Taking the low 16 bits of the integer sum gives the result modulo 2^16
  function automatic logic [63:0] model_pack();
    logic [63:0] r;
    logic [31:0] t;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      t = model_sum[i];
      r[i*16 +: 16] = t[15:0];
    end
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic drive_idle_inputs();
    bus.ap_start    = 1'b0;
    bus.ap_continue = 1'b0;
    bus.len         = 16'd0;
    bus.x           = '0;
    bus.x_ap_vld    = 1'b0;
  endtask

  // One full transaction. The arguments are:
  //   n         number of samples to accumulate
  //   vld_pct   chance in percent that x_ap_vld is high in a cycle
  //   ce_pct    chance in percent that ap_ce is high in a cycle
  //   fix_x     use xv for every sample instead of a random word
  //   use_vpat  take x_ap_vld from vpat, one bit per cycle
  //   use_cpat  take ap_ce from cpat, one bit per cycle
  //   use_dir   also compare acc with dir_val in the first DONE cycle
  task automatic run_txn(input int n, input int vld_pct, input int ce_pct,
                         input bit fix_x, input logic [31:0] xv,
                         input bit use_vpat, input logic [31:0] vpat,
                         input bit use_cpat, input logic [31:0] cpat,
                         input bit use_dir, input logic [63:0] dir_val);
    int acc_n = 0;
    int cyc = 0;
    bit vld;
    bit ce;
    logic [31:0] xw;
    model_clear();
    // Start cycle: a sample offered here must be ignored
    @(posedge ap_clk); #1;
    bus.ap_start = 1'b1;
    bus.len = 16'(n);
    ap_ce = 1'b1;
    bus.x_ap_vld = 1'($urandom_range(0, 1));
    bus.x = $urandom;
    if (n == 0) exp_q.push_back(64'd0);
    @(negedge ap_clk);
    chk("start_ready_idle", {62'd0, bus.ap_ready, bus.ap_idle}, 64'd3);
    @(posedge ap_clk); #1;
    bus.ap_start = 1'b0;
    while (acc_n < n && cyc < 4000) begin
      if (use_vpat && cyc < 32) vld = vpat[cyc];
      else if (use_vpat)        vld = 1'b1;
      else                      vld = ($urandom_range(1, 100) <= vld_pct);
      if (use_cpat && cyc < 32) ce = cpat[cyc];
      else if (use_cpat)        ce = 1'b1;
      else                      ce = ($urandom_range(1, 100) <= ce_pct);
      xw = fix_x ? xv : $urandom;
      bus.x_ap_vld = vld;
      bus.x = xw;
      ap_ce = ce;
      if (vld && ce) begin
        model_add(xw);
        acc_n++;
        if (acc_n == n) exp_q.push_back(model_pack());
      end
      @(negedge ap_clk);
      chk("busy_not_done", {62'd0, bus.ap_idle, bus.ap_done}, 64'd0);
      @(posedge ap_clk); #1;
      cyc++;
    end
    if (acc_n < n) begin
      total++;
      bad++;
      $display("FAIL txn_timeout actual=%0d required=%0d", acc_n, n);
    end
    // First cycle after the final accepted sample: DONE must be visible
    bus.x_ap_vld = 1'($urandom_range(0, 1));
    bus.x = $urandom;
    ap_ce = 1'($urandom_range(0, 1));
    @(negedge ap_clk);
    chk("done_latency", {61'd0, bus.ap_done, bus.acc_ap_vld, bus.ap_idle}, 64'd6);
    if (use_dir) chk("directed_acc", bus.acc, dir_val);
    // Hold DONE while extra valid samples arrive; they must not affect acc
    repeat ($urandom_range(1, 3)) begin
      @(posedge ap_clk); #1;
      bus.x_ap_vld = 1'b1;
      bus.x = $urandom;
      ap_ce = 1'($urandom_range(0, 1));
      @(negedge ap_clk);
      chk("done_held", {63'd0, bus.ap_done}, 64'd1);
    end
    // A continue with ap_ce low is not seen
    @(posedge ap_clk); #1;
    ap_ce = 1'b0;
    bus.ap_continue = 1'b1;
    @(negedge ap_clk);
    chk("ce_blocks_continue", {63'd0, bus.ap_done}, 64'd1);
    // Continue, possibly together with a start that must not be accepted yet
    @(posedge ap_clk); #1;
    ap_ce = 1'b1;
    bus.ap_start = 1'($urandom_range(0, 1));
    bus.len = 16'($urandom_range(0, 5));
    @(negedge ap_clk);
    chk("no_ready_in_done", {63'd0, bus.ap_ready}, 64'd0);
    @(posedge ap_clk); #1;
    drive_idle_inputs();
    @(negedge ap_clk);
    chk("back_to_idle", {62'd0, bus.ap_idle, bus.ap_done}, 64'd2);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    drive_idle_inputs();
    ap_rst_n = 1'b0;
    ap_ce = 1'b0;
    repeat (3) @(negedge ap_clk);
    chk("rst_idle", {63'd0, bus.ap_idle}, 64'd1);
    chk("rst_done_vld_ready", {61'd0, bus.ap_done, bus.acc_ap_vld, bus.ap_ready}, 64'd0);
    chk("rst_acc", bus.acc, 64'd0);

    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    ap_ce = 1'b1;
    // Idle with random samples: they are ignored
    for (int i = 0; i < 4; i++) begin
      bus.x_ap_vld = 1'($urandom_range(0, 1));
      bus.x = $urandom;
      @(negedge ap_clk);
      chk("idle_hold", {62'd0, bus.ap_idle, bus.ap_done}, 64'd2);
      chk("idle_acc", bus.acc, 64'd0);
      @(posedge ap_clk); #1;
    end
    drive_idle_inputs();

    // Mixed-sign lanes, four samples back to back
    run_txn(4, 100, 100, 1'b1, 32'h01FF7F80, 1'b0, 32'd0, 1'b0, 32'd0,
            1'b1, 64'h0004_FFFC_01FC_FE00);
    // Valid pattern 1,0,0,1,1 with len=3
    run_txn(3, 100, 100, 1'b1, 32'h00000001, 1'b1, 32'b11001, 1'b0, 32'd0,
            1'b1, 64'h0000_0000_0000_0003);
    // Zero length
    run_txn(0, 100, 100, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0,
            1'b1, 64'd0);
    // Long run: overflow of lane 0
`ifdef RTL_SACC_SAT_EN
    run_txn(300, 100, 100, 1'b1, 32'h0000007F, 1'b0, 32'd0, 1'b0, 32'd0,
            1'b1, 64'h0000_0000_0000_7FFF);
`else
    run_txn(300, 100, 100, 1'b1, 32'h0000007F, 1'b0, 32'd0, 1'b0, 32'd0,
            1'b1, 64'h0000_0000_0000_94D4);
`endif
    // Two ap_ce=0 cycles in the stream must give the un-stalled result
    run_txn(6, 100, 100, 1'b1, 32'h01020304, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFF3,
            1'b1, 64'h0006_000C_0012_0018);

    // Asynchronous reset in the middle of ACCUM
    @(posedge ap_clk); #1;
    bus.ap_start = 1'b1;
    bus.len = 16'd10;
    ap_ce = 1'b1;
    @(posedge ap_clk); #1;
    bus.ap_start = 1'b0;
    bus.x_ap_vld = 1'b1;
    bus.x = $urandom;
    repeat (4) @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("midrst_state", {61'd0, bus.ap_idle, bus.ap_done, bus.acc_ap_vld}, 64'd4);
    chk("midrst_acc", bus.acc, 64'd0);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    drive_idle_inputs();
    run_txn(5, 100, 100, 1'b1, 32'h10F00302, 1'b0, 32'd0, 1'b0, 32'd0,
            1'b1, 64'h0050_FFB0_000F_000A);

    // Randomized transactions
    for (int t = 0; t < 25; t++) begin
      run_txn($urandom_range(0, 24), $urandom_range(40, 100), $urandom_range(50, 100),
              1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 64'd0);
    end

    repeat (2) @(negedge ap_clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog against a stuck simulation
  initial begin
    #1000000;
    total++;
    bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
